// File: rtl/tone_env_pkg.sv
// Shared types and default constants for the tone envelope sampler and its ADSR core.
// CODEC_SAMPLE_W is the sample width agreed with the audio-codec write interface.
package tone_env_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam int CODEC_SAMPLE_W   = 24;
    localparam int ENV_W_DEF        = 8;
    localparam int SAMPLE_DIV_DEF   = 1042;
    localparam int AMP_SHIFT_DEF    = 15;
    localparam int ATTACK_STEP_DEF  = 4;
    localparam int DECAY_STEP_DEF   = 1;
    localparam int SUSTAIN_LVL_DEF  = 160;
    localparam int RELEASE_STEP_DEF = 2;

endpackage

// File: rtl/tone_envelope_sampler_if.sv
// Valid/ready sample stream toward the audio-codec write FIFO.
// The sampler drives through the master modport, the codec side uses slave.
interface tone_envelope_sampler_if #(
    parameter int W = tone_env_pkg::CODEC_SAMPLE_W
) ();

    logic         sample_valid;
    logic         sample_ready;
    logic [W-1:0] sample_data;

    modport master (
        output sample_valid,
        output sample_data,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output sample_ready
    );

endinterface

// File: rtl/tone_env_adsr.sv
// ADSR envelope state machine; advances only on cycles where tick is high.
// A state change on a tick replaces that tick's step, so levels move on the following tick.
module tone_env_adsr
    import tone_env_pkg::*;
#(
    parameter int ENV_W        = ENV_W_DEF,
    parameter int ATTACK_STEP  = ATTACK_STEP_DEF,
    parameter int DECAY_STEP   = DECAY_STEP_DEF,
    parameter int SUSTAIN_LVL  = SUSTAIN_LVL_DEF,
    parameter int RELEASE_STEP = RELEASE_STEP_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             gate,
    output logic [ENV_W-1:0] env_level,
    output env_state_t       env_state
);

    localparam logic [ENV_W:0]   ENV_MAX = {1'b0, {ENV_W{1'b1}}};
    localparam logic [ENV_W-1:0] ENV_TOP = {ENV_W{1'b1}};
    localparam logic [ENV_W:0]   A_STEP  = (ENV_W+1)'(ATTACK_STEP);
    localparam logic [ENV_W:0]   D_STEP  = (ENV_W+1)'(DECAY_STEP);
    localparam logic [ENV_W:0]   R_STEP  = (ENV_W+1)'(RELEASE_STEP);
    localparam logic [ENV_W:0]   SUS_W   = (ENV_W+1)'(SUSTAIN_LVL);
    localparam logic [ENV_W-1:0] SUS_LVL = ENV_W'(SUSTAIN_LVL);

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [ENV_W:0]   inc_w, dec_w, rel_w;

    // One extra bit on every intermediate exposes overflow/underflow before clamping.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        inc_w   = {1'b0, env_q} + A_STEP;
        dec_w   = {1'b0, env_q} - D_STEP;
        rel_w   = {1'b0, env_q} - R_STEP;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    env_d = '0;
                    if (gate) state_d = ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else if (inc_w >= ENV_MAX) begin
                        env_d   = ENV_TOP;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = inc_w[ENV_W-1:0];
                    end
                end
                ST_DECAY: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else if (dec_w[ENV_W] || (dec_w <= SUS_W)) begin
                        env_d   = SUS_LVL;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = dec_w[ENV_W-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (gate) begin
                        state_d = ST_ATTACK;
                    end else if (rel_w[ENV_W] || (rel_w == '0)) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = rel_w[ENV_W-1:0];
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            env_q   <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    assign env_level = env_q;
    assign env_state = state_q;

endmodule

// File: rtl/tone_envelope_sampler.sv
// Samples the square-wave tone at the audio rate, scales it by an ADSR envelope and
// offers signed PCM to the codec. Define TONE_ENV_OVERRUN_CNT_EN for the overrun counter.
module tone_envelope_sampler
    import tone_env_pkg::*;
#(
    parameter int SAMPLE_W     = CODEC_SAMPLE_W,
    parameter int ENV_W        = ENV_W_DEF,
    parameter int SAMPLE_DIV   = SAMPLE_DIV_DEF,
    parameter int AMP_SHIFT    = AMP_SHIFT_DEF,
    parameter int ATTACK_STEP  = ATTACK_STEP_DEF,
    parameter int DECAY_STEP   = DECAY_STEP_DEF,
    parameter int SUSTAIN_LVL  = SUSTAIN_LVL_DEF,
    parameter int RELEASE_STEP = RELEASE_STEP_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tone_in,
    input  logic                     gate,
    tone_envelope_sampler_if.master  smp,
    output logic [ENV_W-1:0]         env_level,
    output logic [2:0]               env_state
`ifdef TONE_ENV_OVERRUN_CNT_EN
    ,
    input  logic                     overrun_clr,
    output logic [15:0]              overrun_count
`endif
);

    localparam int                CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tick;
    logic                valid_q, valid_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic [SAMPLE_W-1:0] magnitude;
    logic [SAMPLE_W-1:0] new_sample;
    env_state_t          adsr_state;

    assign tick = (cnt_q == CNT_LAST);

    tone_env_adsr #(
        .ENV_W        (ENV_W),
        .ATTACK_STEP  (ATTACK_STEP),
        .DECAY_STEP   (DECAY_STEP),
        .SUSTAIN_LVL  (SUSTAIN_LVL),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_adsr (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .gate      (gate),
        .env_level (env_level),
        .env_state (adsr_state)
    );

    assign env_state = adsr_state;

    // Sample uses the level as it stands before this tick's envelope update.
    assign magnitude  = SAMPLE_W'(env_level) << AMP_SHIFT;
    assign new_sample = tone_in ? magnitude : -magnitude;

    // A held sample that has not been taken blocks the new one; the new one is lost.
    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && smp.sample_ready) valid_d = 1'b0;
        if (tick && (!valid_q || smp.sample_ready)) begin
            valid_d = 1'b1;
            data_d  = new_sample;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign smp.sample_valid = valid_q;
    assign smp.sample_data  = data_q;

`ifdef TONE_ENV_OVERRUN_CNT_EN
    logic        overrun;
    logic [15:0] ovr_q, ovr_d;

    assign overrun = tick && valid_q && !smp.sample_ready;

    always_comb begin
        ovr_d = ovr_q;
        if (overrun_clr) begin
            ovr_d = '0;
        end else if (overrun && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_count = ovr_q;
`endif

endmodule
